retire_commit: RTL and testbench

- Retire stage directly downstream of the completion/ROB stage.
- Consumes up to two in-order retiring ROB entries per cycle (slot a older than slot b).
- Returns superseded physical registers (rd_old) to the free list.
- Commits retired stores to data memory through an in-order store commit FIFO with a valid/ready handshake.
- Maintains a retired-instruction counter.
- Tells the ROB whether it may retire next cycle.

---
 rtl/retire_commit_pkg.sv | 58 +++++
 rtl/retire_commit_store_fifo.sv | 86 ++++++++
 rtl/retire_commit.sv | 107 ++++++++++
 tb/tb_retire_commit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/retire_commit_pkg.sv
// ============================================================================
// Module : retire_commit_pkg
// Brief  : Shared types for the retire stage: ROB entry, control bits,
//          store-queue entry and free-list return record.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package retire_commit_pkg;

  localparam int PREG_W = 6;
  localparam int XLEN   = 32;

  typedef struct packed {
    logic       RegWrite;
    logic       MemRead;
    logic       MemWrite;
    logic       MemtoReg;
    logic       Branch;
    logic       ALUSrc;
    logic [1:0] ALUOp;
  } controlStruct;

  typedef struct packed {
    logic              valid;
    logic              complete;
    logic [XLEN-1:0]   pc;
    logic [PREG_W-1:0] rd;
    logic [PREG_W-1:0] rd_old;
    logic [XLEN-1:0]   result;
    logic [XLEN-1:0]   wr_data;
    controlStruct      control;
  } robEntryStruct;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
  } stqEntryStruct;

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] tag;
  } freeStruct;

  // A retiring entry hands back its old mapping only if it really wrote a
  // non-zero architectural destination.
  function automatic logic frees_preg(input robEntryStruct e);
    return e.valid & e.control.RegWrite & (e.rd != '0);
  endfunction

  // Stores are the only entries that reach data memory at retirement.
  function automatic logic pushes_store(input robEntryStruct e);
    return e.valid & e.control.MemWrite;
  endfunction

endpackage

`default_nettype wire

// File: rtl/retire_commit_store_fifo.sv
// ============================================================================
// Module : store_commit_fifo
// Brief  : In-order store commit FIFO with two ordered push ports (a before
//          b), one pop, occupancy outputs and a sticky overflow flag.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module store_commit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push_a_valid,
  input  logic [WIDTH-1:0]           i_push_a_data,
  input  logic                       i_push_b_valid,
  input  logic [WIDTH-1:0]           i_push_b_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic [$clog2(DEPTH):0]     o_count_next,
  output logic                       o_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CW-1:0]    r_count;
  logic             r_overflow;

  logic             w_pop;
  logic [CW:0]      w_room;
  logic [CW:0]      w_need_b;
  logic             w_acc_a;
  logic             w_acc_b;
  logic             w_drop;
  logic [PTR_W-1:0] w_b_ptr;
  logic [CW-1:0]    w_count_next;

  // Room is computed against the post-pop occupancy so a same-cycle pop frees
  // a slot for an incoming push.
  assign w_pop        = i_pop & (r_count != '0);
  assign w_room       = (CW+1)'(DEPTH) - {1'b0, r_count} + {{CW{1'b0}}, w_pop};
  assign w_need_b     = {{CW{1'b0}}, w_acc_a};
  assign w_acc_a      = i_push_a_valid & (w_room != '0);
  assign w_acc_b      = i_push_b_valid & (w_room > w_need_b);
  assign w_drop       = (i_push_a_valid & ~w_acc_a) | (i_push_b_valid & ~w_acc_b);
  assign w_b_ptr      = w_acc_a ? r_tail + PTR_W'(1) : r_tail;
  assign w_count_next = r_count + CW'(w_acc_a) + CW'(w_acc_b) - CW'(w_pop);

  // Head is read straight from storage; zero when empty so idle outputs are clean.
  assign o_head_data  = (r_count != '0) ? r_mem[r_head] : '0;
  assign o_count      = r_count;
  assign o_count_next = w_count_next;
  assign o_overflow   = r_overflow;

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_head     <= r_head + PTR_W'(w_pop);
      r_tail     <= r_tail + PTR_W'(w_acc_a) + PTR_W'(w_acc_b);
      r_count    <= w_count_next;
      r_overflow <= r_overflow | w_drop;
    end
  end

  // Storage writes; slot a lands at the tail, slot b right behind it.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (w_acc_a) r_mem[r_tail]  <= i_push_a_data;
      if (w_acc_b) r_mem[w_b_ptr] <= i_push_b_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/retire_commit.sv
// ============================================================================
// Module : retire_commit
// Brief  : Dual-slot retire stage: frees superseded physical registers,
//          queues retired stores for memory, counts retired instructions and
//          throttles the ROB when the store queue is nearly full.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module retire_commit
  import retire_commit_pkg::*;
#(
  parameter int STQ_DEPTH = 4,
  parameter int CNT_W     = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  robEntryStruct     retire_a,
  input  robEntryStruct     retire_b,
  output logic              free_a_valid,
  output logic [PREG_W-1:0] free_a_tag,
  output logic              free_b_valid,
  output logic [PREG_W-1:0] free_b_tag,
  output logic              mem_wr_valid,
  output logic [XLEN-1:0]   mem_wr_addr,
  output logic [XLEN-1:0]   mem_wr_data,
  input  logic              mem_wr_ready,
  output logic              retire_ready,
  output logic [CNT_W-1:0]  retired_count,
  output logic              stq_overflow
);

  localparam int STQ_CW = $clog2(STQ_DEPTH) + 1;

  stqEntryStruct     w_push_a;
  stqEntryStruct     w_push_b;
  stqEntryStruct     w_head;
  logic [STQ_CW-1:0] w_stq_count;
  logic [STQ_CW-1:0] w_stq_count_next;
  logic              w_unused;

  freeStruct         r_free_a;
  freeStruct         r_free_b;
  logic              r_retire_ready;
  logic [CNT_W-1:0]  r_retired_count;

  assign w_push_a = '{addr: retire_a.result, data: retire_a.wr_data};
  assign w_push_b = '{addr: retire_b.result, data: retire_b.wr_data};

  store_commit_fifo #(
    .DEPTH (STQ_DEPTH),
    .WIDTH ($bits(stqEntryStruct))
  ) u_stq (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_push_a_valid (pushes_store(retire_a)),
    .i_push_a_data  (w_push_a),
    .i_push_b_valid (pushes_store(retire_b)),
    .i_push_b_data  (w_push_b),
    .i_pop          (mem_wr_valid & mem_wr_ready),
    .o_head_data    (w_head),
    .o_count        (w_stq_count),
    .o_count_next   (w_stq_count_next),
    .o_overflow     (stq_overflow)
  );

  assign mem_wr_valid = (w_stq_count != '0);
  assign mem_wr_addr  = w_head.addr;
  assign mem_wr_data  = w_head.data;

  // Fields the retire stage does not consume.
  assign w_unused = &{1'b0, retire_a.pc, retire_b.pc, retire_a.complete, retire_b.complete};

  // Free-list returns: tag only updates when a register is actually freed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_free_a <= '0;
      r_free_b <= '0;
    end else begin
      r_free_a.valid <= frees_preg(retire_a);
      r_free_b.valid <= frees_preg(retire_b);
      if (frees_preg(retire_a)) r_free_a.tag <= retire_a.rd_old;
      if (frees_preg(retire_b)) r_free_b.tag <= retire_b.rd_old;
    end
  end

  // Retire counter and next-cycle permission; two slots of headroom after pop.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_retired_count <= '0;
      r_retire_ready  <= 1'b1;
    end else begin
      r_retired_count <= r_retired_count + CNT_W'(retire_a.valid) + CNT_W'(retire_b.valid);
      r_retire_ready  <= (w_stq_count_next <= STQ_CW'(STQ_DEPTH - 2));
    end
  end

  assign free_a_valid  = r_free_a.valid;
  assign free_a_tag    = r_free_a.tag;
  assign free_b_valid  = r_free_b.valid;
  assign free_b_tag    = r_free_b.tag;
  assign retire_ready  = r_retire_ready;
  assign retired_count = r_retired_count;

endmodule

`default_nettype wire

// File: tb/tb_retire_commit.sv
// ============================================================================
// Module : tb_retire_commit
// Brief  : Directed self-checking bench for retire_commit (STQ_DEPTH=4,
//          CNT_W=4 so counter wrap is reachable).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_retire_commit;
  import retire_commit_pkg::*;

  logic              clk = 1'b0;
  logic              reset_n;
  robEntryStruct     retire_a;
  robEntryStruct     retire_b;
  logic              free_a_valid;
  logic [PREG_W-1:0] free_a_tag;
  logic              free_b_valid;
  logic [PREG_W-1:0] free_b_tag;
  logic              mem_wr_valid;
  logic [XLEN-1:0]   mem_wr_addr;
  logic [XLEN-1:0]   mem_wr_data;
  logic              mem_wr_ready;
  logic              retire_ready;
  logic [3:0]        retired_count;
  logic              stq_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  retire_commit #(.STQ_DEPTH(4), .CNT_W(4)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .retire_a      (retire_a),
    .retire_b      (retire_b),
    .free_a_valid  (free_a_valid),
    .free_a_tag    (free_a_tag),
    .free_b_valid  (free_b_valid),
    .free_b_tag    (free_b_tag),
    .mem_wr_valid  (mem_wr_valid),
    .mem_wr_addr   (mem_wr_addr),
    .mem_wr_data   (mem_wr_data),
    .mem_wr_ready  (mem_wr_ready),
    .retire_ready  (retire_ready),
    .retired_count (retired_count),
    .stq_overflow  (stq_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic robEntryStruct alu(input logic [5:0] rd, input logic [5:0] rd_old);
    robEntryStruct e;
    e = '0;
    e.valid = 1'b1;
    e.complete = 1'b1;
    e.rd = rd;
    e.rd_old = rd_old;
    e.control.RegWrite = 1'b1;
    return e;
  endfunction

  function automatic robEntryStruct st(input logic [31:0] addr, input logic [31:0] data);
    robEntryStruct e;
    e = '0;
    e.valid = 1'b1;
    e.complete = 1'b1;
    e.result = addr;
    e.wr_data = data;
    e.control.MemWrite = 1'b1;
    return e;
  endfunction

  task automatic idle();
    retire_a = '0;
    retire_b = '0;
  endtask

  initial begin
    // Reset with live inputs present
    reset_n = 1'b0;
    mem_wr_ready = 1'b1;
    retire_a = alu(6'd5, 6'd12);
    retire_b = st(32'h44, 32'h55);
    tick(); tick();
    chk("rst_free_a_valid", free_a_valid, 0);
    chk("rst_free_a_tag", free_a_tag, 0);
    chk("rst_free_b_valid", free_b_valid, 0);
    chk("rst_free_b_tag", free_b_tag, 0);
    chk("rst_mem_wr_valid", mem_wr_valid, 0);
    chk("rst_mem_wr_addr", mem_wr_addr, 0);
    chk("rst_mem_wr_data", mem_wr_data, 0);
    chk("rst_retire_ready", retire_ready, 1);
    chk("rst_retired_count", retired_count, 0);
    chk("rst_overflow", stq_overflow, 0);
    idle();
    mem_wr_ready = 1'b0;
    reset_n = 1'b1;
    tick();
    chk("rel_retire_ready", retire_ready, 1);
    chk("rel_retired_count", retired_count, 0);

    // Dual ALU retire
    retire_a = alu(6'd5, 6'd12);
    retire_b = alu(6'd7, 6'd20);
    tick();
    chk("alu_free_a_valid", free_a_valid, 1);
    chk("alu_free_a_tag", free_a_tag, 12);
    chk("alu_free_b_valid", free_b_valid, 1);
    chk("alu_free_b_tag", free_b_tag, 20);
    chk("alu_count", retired_count, 2);
    chk("alu_mem_wr_valid", mem_wr_valid, 0);

    // rd=0 does not free; store in slot b reaches the head next cycle
    retire_a = alu(6'd0, 6'd3);
    retire_b = st(32'h100, 32'hDEAD);
    tick();
    chk("rd0_free_a_valid", free_a_valid, 0);
    chk("rd0_free_a_tag_hold", free_a_tag, 12);
    chk("st_free_b_valid", free_b_valid, 0);
    chk("st_mem_wr_valid", mem_wr_valid, 1);
    chk("st_mem_wr_addr", mem_wr_addr, 32'h100);
    chk("st_mem_wr_data", mem_wr_data, 32'hDEAD);
    chk("st_count", retired_count, 4);
    idle();
    mem_wr_ready = 1'b1;
    tick();
    chk("st_pop_valid", mem_wr_valid, 0);
    chk("st_pop_count", retired_count, 4);

    // Ordering and backpressure (head/tail wrap past slot 3)
    mem_wr_ready = 1'b0;
    retire_a = st(32'h10, 32'h1);
    tick();
    chk("ord_ready_c1", retire_ready, 1);
    chk("ord_head_c1", mem_wr_addr, 32'h10);
    retire_a = st(32'h20, 32'h2);
    retire_b = st(32'h30, 32'h3);
    tick();
    chk("ord_ready_c3", retire_ready, 0);
    chk("ord_head_hold", mem_wr_addr, 32'h10);
    chk("ord_count", retired_count, 7);
    idle();
    mem_wr_ready = 1'b1;
    tick();
    chk("ord_addr_2", mem_wr_addr, 32'h20);
    chk("ord_data_2", mem_wr_data, 32'h2);
    chk("ord_ready_after_pop", retire_ready, 1);
    tick();
    chk("ord_addr_3", mem_wr_addr, 32'h30);
    tick();
    chk("ord_empty", mem_wr_valid, 0);

    // Overflow: full FIFO, no pop, extra store dropped
    mem_wr_ready = 1'b0;
    retire_a = st(32'hA0, 0); retire_b = st(32'hA1, 0);
    tick();
    retire_a = st(32'hA2, 0); retire_b = st(32'hA3, 0);
    tick();
    chk("ovf_ready_full", retire_ready, 0);
    chk("ovf_flag_pre", stq_overflow, 0);
    retire_a = st(32'hA4, 0); retire_b = '0;
    tick();
    chk("ovf_flag_set", stq_overflow, 1);
    chk("ovf_head", mem_wr_addr, 32'hA0);
    idle();
    tick();
    chk("ovf_flag_sticky", stq_overflow, 1);

    // Mid-operation reset abandons queued stores
    reset_n = 1'b0;
    tick();
    chk("mid_rst_valid", mem_wr_valid, 0);
    chk("mid_rst_overflow", stq_overflow, 0);
    chk("mid_rst_ready", retire_ready, 1);
    reset_n = 1'b1;

    // Full FIFO with simultaneous pop accepts the push
    retire_a = st(32'hB0, 0); retire_b = st(32'hB1, 0);
    tick();
    retire_a = st(32'hB2, 0); retire_b = st(32'hB3, 0);
    tick();
    mem_wr_ready = 1'b1;
    retire_a = st(32'hB4, 0); retire_b = '0;
    tick();
    chk("full_pop_flag", stq_overflow, 0);
    chk("full_pop_ready", retire_ready, 0);
    chk("full_pop_head", mem_wr_addr, 32'hB1);
    idle();
    tick();
    chk("full_pop_b2", mem_wr_addr, 32'hB2);
    tick();
    chk("full_pop_b3", mem_wr_addr, 32'hB3);
    tick();
    chk("full_pop_b4", mem_wr_addr, 32'hB4);
    tick();
    chk("full_pop_empty", mem_wr_valid, 0);

    // Counter wrap with CNT_W=4, then slot b alone
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      retire_a = alu(6'd1, 6'd2);
      retire_b = alu(6'd3, 6'd4);
      tick();
      if (i == 6) chk("wrap_count_14", retired_count, 14);
    end
    chk("wrap_count_0", retired_count, 0);
    retire_a = '0;
    retire_b = alu(6'd9, 6'd33);
    tick();
    chk("bonly_count", retired_count, 1);
    chk("bonly_free_b_valid", free_b_valid, 1);
    chk("bonly_free_b_tag", free_b_tag, 33);
    chk("bonly_free_a_valid", free_a_valid, 0);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
